// File: rtl/lagarto_fpu_pkg.sv
// Shared Lagarto FPU types: unit interface bundles, formats, op codes,
// canonical NaNs and classify bit positions.
package lagarto_fpu_pkg;

  localparam int unsigned FP64_EXP_W = 11;
  localparam int unsigned FP64_MAN_W = 52;
  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;

  localparam int unsigned TAG_W   = 8;
  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 4;

  localparam logic [63:0] CANON_NAN_64 = 64'h7FF8000000000000;
  localparam logic [63:0] CANON_NAN_32 = 64'hFFFFFFFF7FC00000;
  localparam logic [63:0] CANON_NAN_16 = 64'hFFFFFFFFFFFF7E00;

  localparam logic [63:0] BOX_MASK_32 = 64'hFFFFFFFF00000000;
  localparam logic [63:0] BOX_MASK_16 = 64'hFFFFFFFFFFFF0000;

  localparam int unsigned CLS_NEG_INF  = 0;
  localparam int unsigned CLS_NEG_NORM = 1;
  localparam int unsigned CLS_NEG_SUB  = 2;
  localparam int unsigned CLS_NEG_ZERO = 3;
  localparam int unsigned CLS_POS_ZERO = 4;
  localparam int unsigned CLS_POS_SUB  = 5;
  localparam int unsigned CLS_POS_NORM = 6;
  localparam int unsigned CLS_POS_INF  = 7;
  localparam int unsigned CLS_SNAN     = 8;
  localparam int unsigned CLS_QNAN     = 9;

  typedef enum logic [1:0] {
    FMT_FP64 = 2'd0,
    FMT_FP32 = 2'd1,
    FMT_FP16 = 2'd2,
    FMT_FP8  = 2'd3
  } fmt_t;

  typedef enum logic [3:0] {
    OP_FADD   = 4'd0,
    OP_FSUB   = 4'd1,
    OP_FMUL   = 4'd2,
    OP_FDIV   = 4'd3,
    OP_FSQRT  = 4'd4,
    OP_FMADD  = 4'd5,
    OP_SGNJ   = 4'd6,
    OP_SGNJN  = 4'd7,
    OP_SGNJX  = 4'd8,
    OP_MIN    = 4'd9,
    OP_MAX    = 4'd10,
    OP_CMP_EQ = 4'd11,
    OP_CMP_LO = 4'd12,
    OP_CMP_LE = 4'd13,
    OP_CLASS  = 4'd14,
    OP_CVT    = 4'd15
  } op_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic             op_valid;
    op_t              op;
    fmt_t             fmt;
    logic [2:0]       rnd_mode;
    logic [63:0]      operand_a;
    logic [63:0]      operand_b;
    logic [63:0]      operand_c;
    logic [TAG_W-1:0] tag_id;
  } unit_input_t;

  typedef struct packed {
    logic             op_ready;
    logic [63:0]      result;
    status_t          status;
    logic [TAG_W-1:0] tag_id;
    logic             busy;
  } unit_output_t;

  typedef struct packed {
    logic [63:0]      result;
    status_t          status;
    logic [TAG_W-1:0] tag;
  } noncomp_stage_t;

  function automatic logic [63:0] canon_nan(input fmt_t fmt);
    case (fmt)
      FMT_FP32: return CANON_NAN_32;
      FMT_FP16: return CANON_NAN_16;
      default:  return CANON_NAN_64;
    endcase
  endfunction

  function automatic logic [63:0] inject_sign(input logic [63:0] v,
                                              input fmt_t fmt,
                                              input logic s);
    logic [63:0] r;
    r = v;
    case (fmt)
      FMT_FP32: r[31] = s;
      FMT_FP16: r[15] = s;
      default:  r[63] = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lagarto_fpu_operand_decode.sv
// Unboxes one FP operand and widens its fields to FP64 layout so that
// a single magnitude comparator serves every format.
module lagarto_fpu_operand_decode
  import lagarto_fpu_pkg::*;
(
  input  logic [63:0] value_i,
  input  fmt_t        fmt_i,
  output logic [63:0] value_o,
  output logic        sign_o,
  output logic [10:0] exp_o,
  output logic [51:0] man_o,
  output logic        is_zero_o,
  output logic        is_subnormal_o,
  output logic        is_normal_o,
  output logic        is_inf_o,
  output logic        is_snan_o,
  output logic        is_qnan_o,
  output logic        is_boxed_o
);

  logic exp_max;
  logic exp_zero;
  logic man_zero;

  always_comb begin
    is_boxed_o = 1'b1;
    value_o    = value_i;
    sign_o     = value_i[63];
    exp_o      = value_i[62:52];
    man_o      = value_i[51:0];
    exp_max    = &value_i[62:52];
    case (fmt_i)
      FMT_FP32: begin
        is_boxed_o = (value_i & BOX_MASK_32) == BOX_MASK_32;
        value_o    = is_boxed_o ? value_i : CANON_NAN_32;
        sign_o     = value_o[31];
        exp_o      = {{(FP64_EXP_W-FP32_EXP_W){1'b0}}, value_o[30:23]};
        man_o      = {value_o[22:0], {(FP64_MAN_W-FP32_MAN_W){1'b0}}};
        exp_max    = &value_o[30:23];
      end
      FMT_FP16: begin
        is_boxed_o = (value_i & BOX_MASK_16) == BOX_MASK_16;
        value_o    = is_boxed_o ? value_i : CANON_NAN_16;
        sign_o     = value_o[15];
        exp_o      = {{(FP64_EXP_W-FP16_EXP_W){1'b0}}, value_o[14:10]};
        man_o      = {value_o[9:0], {(FP64_MAN_W-FP16_MAN_W){1'b0}}};
        exp_max    = &value_o[14:10];
      end
      default: ;
    endcase
    exp_zero       = exp_o == '0;
    man_zero       = man_o == '0;
    is_zero_o      = exp_zero & man_zero;
    is_subnormal_o = exp_zero & !man_zero;
    is_normal_o    = !exp_zero & !exp_max;
    is_inf_o       = exp_max & man_zero;
    is_snan_o      = exp_max & !man_zero & !man_o[51];
    is_qnan_o      = exp_max & man_o[51];
  end

endmodule

// File: rtl/lagarto_fpu_noncomp_unit.sv
// Non-computational FP unit: sign injection, min/max, compares, classify,
// followed by an elastic pipeline with backpressure and flush.
module lagarto_fpu_noncomp_unit
  import lagarto_fpu_pkg::*;
#(
  parameter int unsigned LATENCY      = 2,
  parameter bit          SUPPORT_FP16 = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  unit_input_t  unit_input_i,
  output logic         ready_o,
  input  logic         result_ready_i,
  output unit_output_t unit_output_o
);

  localparam int unsigned NSTG =
    (LATENCY < LAT_MIN) ? LAT_MIN :
    (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

  fmt_t        fmt;
  logic [63:0] a_val, b_val;
  logic        a_sign, b_sign;
  logic [10:0] a_exp, b_exp;
  logic [51:0] a_man, b_man;
  logic        a_zero, a_sub, a_norm, a_inf, a_snan, a_qnan, a_boxed;
  logic        b_zero, b_sub, b_norm, b_inf, b_snan, b_qnan, b_boxed;

  assign fmt = unit_input_i.fmt;

  lagarto_fpu_operand_decode u_dec_a (
    .value_i        (unit_input_i.operand_a),
    .fmt_i          (fmt),
    .value_o        (a_val),
    .sign_o         (a_sign),
    .exp_o          (a_exp),
    .man_o          (a_man),
    .is_zero_o      (a_zero),
    .is_subnormal_o (a_sub),
    .is_normal_o    (a_norm),
    .is_inf_o       (a_inf),
    .is_snan_o      (a_snan),
    .is_qnan_o      (a_qnan),
    .is_boxed_o     (a_boxed)
  );

  lagarto_fpu_operand_decode u_dec_b (
    .value_i        (unit_input_i.operand_b),
    .fmt_i          (fmt),
    .value_o        (b_val),
    .sign_o         (b_sign),
    .exp_o          (b_exp),
    .man_o          (b_man),
    .is_zero_o      (b_zero),
    .is_subnormal_o (b_sub),
    .is_normal_o    (b_norm),
    .is_inf_o       (b_inf),
    .is_snan_o      (b_snan),
    .is_qnan_o      (b_qnan),
    .is_boxed_o     (b_boxed)
  );

  logic unused_in;
  assign unused_in = ^{a_boxed, b_boxed, b_sub, b_norm, b_inf,
                       unit_input_i.rnd_mode, unit_input_i.operand_c};

  logic       a_nan, b_nan, any_nan, any_snan;
  logic       mag_lt, mag_gt, lt_tot, both_zero, eq, lt;
  logic       fmt_ok;
  logic [9:0] cls;

  always_comb begin
    a_nan     = a_snan | a_qnan;
    b_nan     = b_snan | b_qnan;
    any_nan   = a_nan | b_nan;
    any_snan  = a_snan | b_snan;
    mag_lt    = {a_exp, a_man} < {b_exp, b_man};
    mag_gt    = {a_exp, a_man} > {b_exp, b_man};
    // total order with -0 below +0; compares mask the zero case below
    lt_tot    = (a_sign != b_sign) ? a_sign : (a_sign ? mag_gt : mag_lt);
    both_zero = a_zero & b_zero;
    eq        = both_zero |
                ({a_sign, a_exp, a_man} == {b_sign, b_exp, b_man});
    lt        = lt_tot & !both_zero;
    fmt_ok    = (fmt == FMT_FP64) | (fmt == FMT_FP32) |
                ((fmt == FMT_FP16) & SUPPORT_FP16);
    cls                = '0;
    cls[CLS_NEG_INF]   = a_sign & a_inf;
    cls[CLS_NEG_NORM]  = a_sign & a_norm;
    cls[CLS_NEG_SUB]   = a_sign & a_sub;
    cls[CLS_NEG_ZERO]  = a_sign & a_zero;
    cls[CLS_POS_ZERO]  = !a_sign & a_zero;
    cls[CLS_POS_SUB]   = !a_sign & a_sub;
    cls[CLS_POS_NORM]  = !a_sign & a_norm;
    cls[CLS_POS_INF]   = !a_sign & a_inf;
    cls[CLS_SNAN]      = a_snan;
    cls[CLS_QNAN]      = a_qnan;
  end

  logic [63:0] res;
  logic        nv;

  always_comb begin
    res = '0;
    nv  = 1'b0;
    case (unit_input_i.op)
      OP_SGNJ:  res = inject_sign(a_val, fmt, b_sign);
      OP_SGNJN: res = inject_sign(a_val, fmt, ~b_sign);
      OP_SGNJX: res = inject_sign(a_val, fmt, a_sign ^ b_sign);
      OP_MIN, OP_MAX: begin
        nv = any_snan;
        if (a_nan & b_nan)
          res = canon_nan(fmt);
        else if (a_nan)
          res = b_val;
        else if (b_nan)
          res = a_val;
        else if (unit_input_i.op == OP_MIN)
          res = lt_tot ? a_val : b_val;
        else
          res = lt_tot ? b_val : a_val;
      end
      OP_CMP_EQ: begin
        res = {63'b0, !any_nan & eq};
        nv  = any_snan;
      end
      OP_CMP_LO: begin
        res = {63'b0, !any_nan & lt};
        nv  = any_nan;
      end
      OP_CMP_LE: begin
        res = {63'b0, !any_nan & (lt | eq)};
        nv  = any_nan;
      end
      OP_CLASS: res = {54'b0, cls};
      default:  nv = 1'b1;
    endcase
    if (!fmt_ok) begin
      res = '0;
      nv  = 1'b1;
    end
  end

  noncomp_stage_t new_stg;

  always_comb begin
    new_stg           = '0;
    new_stg.result    = res;
    new_stg.status.nv = nv;
    new_stg.tag       = unit_input_i.tag_id;
  end

  logic [NSTG-1:0]                 vld;
  logic [NSTG-1:0]                 en;
  logic [NSTG-1:0]                 adv;
  noncomp_stage_t [NSTG-1:0]       stg;
  logic [NSTG:0]                   occ;
  logic [NSTG:0]                   go;
  logic                            accept;

  // a virtual always-full stage past the end makes the last stage
  // advance on result_ready_i alone
  always_comb begin
    occ       = {1'b1, vld};
    go        = '0;
    go[NSTG]  = result_ready_i;
    for (int i = NSTG - 1; i >= 0; i--)
      go[i] = occ[i] & (!occ[i+1] | go[i+1]);
    adv     = go[NSTG-1:0];
    ready_o = !vld[0] | adv[0];
    accept  = unit_input_i.op_valid & ready_o & !flush_i;
  end

  for (genvar g = 0; g < NSTG; g++) begin : g_stage
    logic           vld_q, vld_d;
    noncomp_stage_t stg_q, stg_d, stg_in;

    if (g == 0) begin : g_head
      assign en[g]  = accept;
      assign stg_in = new_stg;
    end else begin : g_tail
      assign en[g]  = adv[g-1];
      assign stg_in = stg[g-1];
    end

    always_comb begin
      vld_d = vld_q;
      stg_d = stg_q;
      if (en[g]) begin
        vld_d = 1'b1;
        stg_d = stg_in;
      end else if (adv[g]) begin
        vld_d = 1'b0;
      end
      if (flush_i)
        vld_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= 1'b0;
        stg_q <= '0;
      end else begin
        vld_q <= vld_d;
        stg_q <= stg_d;
      end
    end

    assign vld[g] = vld_q;
    assign stg[g] = stg_q;
  end

  always_comb begin
    unit_output_o      = '0;
    unit_output_o.busy = |vld;
    if (vld[NSTG-1]) begin
      unit_output_o.op_ready = 1'b1;
      unit_output_o.result   = stg[NSTG-1].result;
      unit_output_o.status   = stg[NSTG-1].status;
      unit_output_o.tag_id   = stg[NSTG-1].tag;
    end
  end

endmodule

// File: tb/tb_lagarto_fpu_noncomp_unit.sv
// Directed vector bench for the non-computational FP unit, plus
// backpressure, flush and reset sequences.
module tb_lagarto_fpu_noncomp_unit;
  import lagarto_fpu_pkg::*;

  localparam int LAT = 2;
  localparam int NV  = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         rr;
  logic         rr2;
  unit_input_t  in_s;
  logic         rdy, rdy2;
  unit_output_t out_s, out2_s;

  always #5 clk = ~clk;

  lagarto_fpu_noncomp_unit #(.LATENCY(LAT), .SUPPORT_FP16(1'b1)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .unit_input_i   (in_s),
    .ready_o        (rdy),
    .result_ready_i (rr),
    .unit_output_o  (out_s)
  );

  lagarto_fpu_noncomp_unit #(.LATENCY(1), .SUPPORT_FP16(1'b0)) u_dut_nofp16 (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .unit_input_i   (in_s),
    .ready_o        (rdy2),
    .result_ready_i (rr2),
    .unit_output_o  (out2_s)
  );

  typedef struct {
    op_t         op;
    fmt_t        fmt;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        nv;
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input op_t op, input fmt_t fmt, input logic [63:0] a,
                       input logic [63:0] b, input logic [7:0] tag);
    in_s           = '0;
    in_s.op_valid  = 1'b1;
    in_s.op        = op;
    in_s.fmt       = fmt;
    in_s.rnd_mode  = 3'd7;
    in_s.operand_a = a;
    in_s.operand_b = b;
    in_s.operand_c = 64'hDEADBEEFDEADBEEF;
    in_s.tag_id    = tag;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] e2_res;
    logic        e2_nv;
    logic        o2_rdy;
    logic [63:0] o2_res;
    logic [4:0]  o2_st;
    logic [7:0]  o2_tag;
    int          n;
    int          k;
    int          cyc;
    logic        acc;
    logic        seen;
    logic [7:0]  got[$];

    vecs[0]  = '{OP_MIN,    FMT_FP64, 64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000000, 1'b0};
    vecs[1]  = '{OP_MAX,    FMT_FP64, 64'h8000000000000000, 64'h0000000000000000, 64'h0000000000000000, 1'b0};
    vecs[2]  = '{OP_CMP_LO, FMT_FP32, 64'hFFFFFFFF7FA00000, 64'hFFFFFFFF3F800000, 64'h0, 1'b1};
    vecs[3]  = '{OP_CMP_EQ, FMT_FP32, 64'hFFFFFFFF7FA00000, 64'hFFFFFFFF3F800000, 64'h0, 1'b1};
    vecs[4]  = '{OP_CMP_EQ, FMT_FP32, 64'hFFFFFFFF7FC00000, 64'hFFFFFFFF3F800000, 64'h0, 1'b0};
    vecs[5]  = '{OP_SGNJN,  FMT_FP32, 64'h000000003F800000, 64'hFFFFFFFF3F800000, 64'hFFFFFFFFFFC00000, 1'b0};
    vecs[6]  = '{OP_CLASS,  FMT_FP16, 64'hFFFFFFFFFFFF0001, 64'h0, 64'h20, 1'b0};
    vecs[7]  = '{OP_CMP_LE, FMT_FP64, 64'h0000000000000000, 64'h8000000000000000, 64'h1, 1'b0};
    vecs[8]  = '{OP_CMP_EQ, FMT_FP64, 64'h0000000000000000, 64'h8000000000000000, 64'h1, 1'b0};
    vecs[9]  = '{OP_CMP_LO, FMT_FP64, 64'h3FF0000000000000, 64'h4000000000000000, 64'h1, 1'b0};
    vecs[10] = '{OP_CMP_LO, FMT_FP64, 64'hBFF0000000000000, 64'hC000000000000000, 64'h0, 1'b0};
    vecs[11] = '{OP_MIN,    FMT_FP32, 64'hFFFFFFFF7FC00000, 64'hFFFFFFFFBF800000, 64'hFFFFFFFFBF800000, 1'b0};
    vecs[12] = '{OP_MAX,    FMT_FP64, 64'h7FF4000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000, 1'b1};
    vecs[13] = '{OP_SGNJX,  FMT_FP64, 64'hC000000000000000, 64'h8000000000000000, 64'h4000000000000000, 1'b0};
    vecs[14] = '{OP_SGNJ,   FMT_FP16, 64'hFFFFFFFFFFFF3C00, 64'hFFFFFFFFFFFF8000, 64'hFFFFFFFFFFFFBC00, 1'b0};
    vecs[15] = '{OP_CLASS,  FMT_FP64, 64'hFFF0000000000000, 64'h0, 64'h1, 1'b0};
    vecs[16] = '{OP_CLASS,  FMT_FP64, 64'h7FF0000000000001, 64'h0, 64'h100, 1'b0};
    vecs[17] = '{OP_CLASS,  FMT_FP32, 64'hFFFFFFFF80000000, 64'h0, 64'h8, 1'b0};
    vecs[18] = '{OP_CLASS,  FMT_FP32, 64'h0000000000000000, 64'h0, 64'h200, 1'b0};
    vecs[19] = '{OP_MIN,    FMT_FP8,  64'h1, 64'h2, 64'h0, 1'b1};
    vecs[20] = '{OP_FADD,   FMT_FP64, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0, 1'b1};
    vecs[21] = '{OP_CLASS,  FMT_FP16, 64'hFFFFFFFFFFFF7C00, 64'h0, 64'h80, 1'b0};
    vecs[22] = '{OP_MIN,    FMT_FP16, 64'hFFFFFFFFFFFFC000, 64'hFFFFFFFFFFFF3C00, 64'hFFFFFFFFFFFFC000, 1'b0};
    vecs[23] = '{OP_SGNJ,   FMT_FP64, 64'h7FF0000000000001, 64'h8000000000000000, 64'hFFF0000000000001, 1'b0};

    rst   = 1'b1;
    flush = 1'b0;
    rr    = 1'b1;
    rr2   = 1'b1;
    in_s  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", 64'(out_s.op_ready), 64'd0);
    chk("rst_result", out_s.result, 64'd0);
    chk("rst_status", 64'(out_s.status), 64'd0);
    chk("rst_tag", 64'(out_s.tag_id), 64'd0);
    chk("rst_busy", 64'(out_s.busy), 64'd0);
    chk("rst_ready", 64'(rdy), 64'd1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].fmt, vecs[i].a, vecs[i].b, 8'(i));
      @(posedge clk);
      @(negedge clk);
      in_s.op_valid = 1'b0;
      o2_rdy = out2_s.op_ready;
      o2_res = out2_s.result;
      o2_st  = out2_s.status;
      o2_tag = out2_s.tag_id;
      n = 1;
      while (!out_s.op_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_latency", i), 64'(n), 64'(LAT));
      chk($sformatf("v%0d_result", i), out_s.result, vecs[i].res);
      chk($sformatf("v%0d_status", i), 64'(out_s.status), 64'({vecs[i].nv, 4'b0}));
      chk($sformatf("v%0d_tag", i), 64'(out_s.tag_id), 64'(i));
      if (vecs[i].fmt == FMT_FP16) begin
        e2_res = 64'h0;
        e2_nv  = 1'b1;
      end else begin
        e2_res = vecs[i].res;
        e2_nv  = vecs[i].nv;
      end
      chk($sformatf("v%0d_nofp16_ready", i), 64'(o2_rdy), 64'd1);
      chk($sformatf("v%0d_nofp16_result", i), o2_res, e2_res);
      chk($sformatf("v%0d_nofp16_status", i), 64'(o2_st), 64'({e2_nv, 4'b0}));
      chk($sformatf("v%0d_nofp16_tag", i), 64'(o2_tag), 64'(i));
    end

    // backpressure: 5 back-to-back ops, sink stalled 6 cycles
    @(negedge clk);
    in_s.op_valid = 1'b0;
    rr = 1'b0;
    k  = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 5)
        drive(OP_SGNJ, FMT_FP64, 64'h3FF0000000000000 + 64'(k), 64'h0, 8'(k));
      else
        in_s.op_valid = 1'b0;
      #1 acc = rdy & in_s.op_valid;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    chk("bp_accepted", 64'(k), 64'(LAT));
    chk("bp_ready_low", 64'(rdy), 64'd0);
    chk("bp_held_valid", 64'(out_s.op_ready), 64'd1);
    chk("bp_held_tag", 64'(out_s.tag_id), 64'd0);
    chk("bp_held_result", out_s.result, 64'h3FF0000000000000);
    rr  = 1'b1;
    cyc = 0;
    got.delete();
    while ((got.size() < 5 || k < 5) && cyc < 40) begin
      if (out_s.op_ready) got.push_back(out_s.tag_id);
      if (k < 5)
        drive(OP_SGNJ, FMT_FP64, 64'h3FF0000000000000 + 64'(k), 64'h0, 8'(k));
      else
        in_s.op_valid = 1'b0;
      #1 acc = rdy & in_s.op_valid;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
      cyc++;
    end
    in_s.op_valid = 1'b0;
    chk("bp_count", 64'(got.size()), 64'd5);
    for (int j = 0; j < got.size(); j++)
      chk($sformatf("bp_order%0d", j), 64'(got[j]), 64'(j));

    // flush with one op in flight
    @(negedge clk);
    drive(OP_CLASS, FMT_FP64, 64'h0, 64'h0, 8'd9);
    @(posedge clk);
    @(negedge clk);
    in_s.op_valid = 1'b0;
    chk("fl_busy_before", 64'(out_s.busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy_after", 64'(out_s.busy), 64'd0);
    chk("fl_ready_after", 64'(out_s.op_ready), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | out_s.op_ready;
    end
    chk("fl_tag9_gone", 64'(seen), 64'd0);

    // flush wins over accept in the same cycle
    drive(OP_CLASS, FMT_FP64, 64'h0, 64'h0, 8'd10);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_s.op_valid = 1'b0;
    flush = 1'b0;
    chk("fl_accept_busy", 64'(out_s.busy), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | out_s.op_ready;
    end
    chk("fl_tag10_gone", 64'(seen), 64'd0);

    // reset while a result is held by backpressure
    rr = 1'b0;
    drive(OP_MAX, FMT_FP64, 64'h4000000000000000, 64'h3FF0000000000000, 8'd11);
    @(posedge clk);
    @(negedge clk);
    in_s.op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_held_tag", 64'(out_s.tag_id), 64'd11);
    chk("mr_held_result", out_s.result, 64'h4000000000000000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr  = 1'b1;
    chk("mr_op_ready", 64'(out_s.op_ready), 64'd0);
    chk("mr_result", out_s.result, 64'd0);
    chk("mr_tag", 64'(out_s.tag_id), 64'd0);
    chk("mr_busy", 64'(out_s.busy), 64'd0);
    chk("mr_ready", 64'(rdy), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
